// File: rtl/hazard_scheduler.sv
// Decode-stage issue scheduler: tracks in-flight writers in a 3-entry shift scoreboard,
// stalls RAW hazards, flushes on taken branches, drains the pipe on HALT, counts stalls.
module hazard_sb_match (
  input  logic       v,
  input  logic [2:0] dst,
  input  logic [2:0] rs,
  input  logic [2:0] rt,
  input  logic       use_rs,
  input  logic       use_rt,
  output logic       hit
);
  assign hit = v & ((use_rs & (dst == rs)) | (use_rt & (dst == rt)));
endmodule

module hazard_scheduler #(
  parameter int STALL_MAX = 4,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_IFID,
  input  logic [2:0]       rs_IFID,
  input  logic [2:0]       rt_IFID,
  input  logic             useRs,
  input  logic             useRt,
  input  logic [2:0]       WrR,
  input  logic             RegWrite,
  input  logic             halt_IFID,
  input  logic             takeBranch_EXMEM,
  output logic             stallCtrl,
  output logic             pcWrEn,
  output logic             ifidWrEn,
  output logic             flush_IFID,
  output logic             halted,
  output logic [CNT_W-1:0] stallCnt,
  output logic             err
);
  localparam int NUM_ENT = 3;
  localparam int RUN_W   = $clog2(STALL_MAX + 2);

  typedef struct packed {
    logic       v;
    logic [2:0] dst;
  } sb_ent_t;

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  sb_ent_t [NUM_ENT-1:0] sb;  // sb[0]=E1 (ID/EX) .. sb[2]=E3 (MEM/WB)
  logic    [NUM_ENT-1:0] hit;
  logic                  hz;
  state_t                state, state_nx;
  logic    [1:0]         drain_cnt, drain_nx;
  logic    [RUN_W-1:0]   run_len;

  for (genvar k = 0; k < NUM_ENT; k++) begin : g_ent
    hazard_sb_match u_match (
      .v      (sb[k].v),
      .dst    (sb[k].dst),
      .rs     (rs_IFID),
      .rt     (rt_IFID),
      .use_rs (useRs),
      .use_rt (useRt),
      .hit    (hit[k])
    );
  end

  assign hz = valid_IFID & (|hit);

  always_comb begin
    state_nx   = state;
    drain_nx   = drain_cnt;
    stallCtrl  = 1'b0;
    pcWrEn     = 1'b1;
    ifidWrEn   = 1'b1;
    flush_IFID = 1'b0;
    halted     = 1'b0;
    case (state)
      RUN: begin
        stallCtrl  = hz & ~takeBranch_EXMEM;
        flush_IFID = takeBranch_EXMEM;
        pcWrEn     = ~stallCtrl;
        ifidWrEn   = ~stallCtrl;
        if (valid_IFID & halt_IFID & ~stallCtrl & ~takeBranch_EXMEM) begin
          state_nx = DRAIN;
          drain_nx = 2'd3;
        end
      end
      DRAIN: begin
        // a taken branch means the HALT was fetched down a wrong path
        pcWrEn     = takeBranch_EXMEM;
        ifidWrEn   = takeBranch_EXMEM;
        flush_IFID = takeBranch_EXMEM;
        if (takeBranch_EXMEM) state_nx = RUN;
        else begin
          drain_nx = drain_cnt - 2'd1;
          if (drain_cnt == 2'd1) state_nx = HALTED;
        end
      end
      HALTED: begin
        pcWrEn   = 1'b0;
        ifidWrEn = 1'b0;
        halted   = 1'b1;
      end
      default: state_nx = RUN;
    endcase
    if (!rst) begin
      stallCtrl  = 1'b0;
      pcWrEn     = 1'b1;
      ifidWrEn   = 1'b1;
      flush_IFID = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb        <= '0;
      state     <= RUN;
      drain_cnt <= '0;
      stallCnt  <= '0;
      run_len   <= '0;
      err       <= 1'b0;
    end else begin
      state     <= state_nx;
      drain_cnt <= drain_nx;
      for (int k = NUM_ENT - 1; k > 0; k--) sb[k] <= sb[k-1];
      sb[0].v   <= valid_IFID & RegWrite & ~stallCtrl & ~takeBranch_EXMEM;
      sb[0].dst <= WrR;
      if (stallCtrl) begin
        if (stallCnt != '1) stallCnt <= stallCnt + 1'b1;
        // run length saturates at STALL_MAX; one more stall trips the watchdog
        if (run_len == RUN_W'(STALL_MAX)) err <= 1'b1;
        else run_len <= run_len + 1'b1;
      end else begin
        run_len <= '0;
      end
    end
  end
endmodule

// File: tb/tb_hazard_scheduler.sv
// Scoreboard bench for hazard_scheduler: directed scenarios plus random traffic,
// checked against a behavioural model of in-flight writers, halt drain and counters.
module tb_hazard_scheduler;
  localparam int STALL_MAX = 4;
  localparam int CNT_W     = 16;

  logic clk = 1'b0, rst = 1'b0;
  logic valid_IFID = 0, useRs = 0, useRt = 0, RegWrite = 0, halt_IFID = 0, takeBranch_EXMEM = 0;
  logic [2:0] rs_IFID = 0, rt_IFID = 0, WrR = 0;
  logic stallCtrl, pcWrEn, ifidWrEn, flush_IFID, halted, err;
  logic [CNT_W-1:0] stallCnt;

  always #5 clk = ~clk;

  hazard_scheduler #(.STALL_MAX(STALL_MAX), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .valid_IFID(valid_IFID), .rs_IFID(rs_IFID), .rt_IFID(rt_IFID),
    .useRs(useRs), .useRt(useRt), .WrR(WrR), .RegWrite(RegWrite), .halt_IFID(halt_IFID),
    .takeBranch_EXMEM(takeBranch_EXMEM), .stallCtrl(stallCtrl), .pcWrEn(pcWrEn),
    .ifidWrEn(ifidWrEn), .flush_IFID(flush_IFID), .halted(halted), .stallCnt(stallCnt), .err(err)
  );

  typedef struct {
    bit sc, pc, ifid, fl, hl, er;
    int cnt;
  } exp_t;
  exp_t q[$];

  int errors = 0, checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: list of writers still in flight (youngest first), counters, halt phase
  bit m_v[3];
  int m_d[3];
  int m_cnt, m_run;
  bit m_err;
  int m_mode;   // 0 running, 1 draining, 2 halted
  int m_left;
  bit f_hz;

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin m_v[k] = 0; m_d[k] = 0; end
    m_cnt = 0; m_run = 0; m_err = 0; m_mode = 0; m_left = 0;
  endtask

  // Drive one instruction slot, predict this cycle's outputs, advance the model one edge.
  task automatic drive(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                       input int wr, input bit rw, input bit hlt, input bit tb);
    bit hz, stall;
    exp_t e;
    valid_IFID = v; rs_IFID = 3'(rs); rt_IFID = 3'(rt); useRs = urs; useRt = urt;
    WrR = 3'(wr); RegWrite = rw; halt_IFID = hlt; takeBranch_EXMEM = tb;
    hz = 0;
    for (int k = 0; k < 3; k++)
      if (m_v[k] && ((urs && m_d[k] == rs) || (urt && m_d[k] == rt))) hz = v;
    if (f_hz) hz = 1;
    stall  = hz && !tb && m_mode == 0;
    e.sc   = stall;
    e.fl   = tb && m_mode != 2;
    e.pc   = (m_mode == 0) ? !stall : (m_mode == 1) ? tb : 1'b0;
    e.ifid = e.pc;
    e.hl   = (m_mode == 2);
    e.er   = m_err;
    e.cnt  = m_cnt;
    q.push_back(e);
    m_v[2] = m_v[1]; m_d[2] = m_d[1];
    m_v[1] = m_v[0]; m_d[1] = m_d[0];
    m_v[0] = v && rw && !stall && !tb; m_d[0] = wr;
    if (stall) begin
      if (m_cnt < 65535) m_cnt++;
      m_run++;
      if (m_run > STALL_MAX) m_err = 1;
    end else m_run = 0;
    case (m_mode)
      0: if (v && hlt && !stall && !tb) begin m_mode = 1; m_left = 3; end
      1: if (tb) m_mode = 0;
         else if (m_left == 1) m_mode = 2;
         else m_left--;
      default: ;
    endcase
    @(posedge clk); #1;
  endtask

  task automatic nop(input bit tb = 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, tb);
  endtask

  // Reset asserted mid-cycle; outputs must react without waiting for an edge.
  task automatic do_reset();
    #2 rst = 0;
    #1;
    chk("rst_stallCtrl", stallCtrl, 0);
    chk("rst_pcWrEn", pcWrEn, 1);
    chk("rst_ifidWrEn", ifidWrEn, 1);
    chk("rst_flush", flush_IFID, 0);
    chk("rst_stallCnt", stallCnt, 0);
    chk("rst_err", err, 0);
    chk("rst_halted", halted, 0);
    model_reset();
    @(posedge clk); #1 rst = 1;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("stallCtrl", stallCtrl, e.sc);
        chk("pcWrEn", pcWrEn, e.pc);
        chk("ifidWrEn", ifidWrEn, e.ifid);
        chk("flush_IFID", flush_IFID, e.fl);
        chk("halted", halted, e.hl);
        chk("err", err, e.er);
        chk("stallCnt", stallCnt, e.cnt);
      end
    end
  end

  initial begin
    f_hz = 0;
    model_reset();
    @(posedge clk); #1 rst = 1;

    // 1: reset in the middle of a RAW stall
    drive(1, 0, 0, 0, 0, 3, 1, 0, 0);
    drive(1, 3, 0, 1, 0, 0, 0, 0, 0);
    do_reset();

    // 2: RAW against previous instruction -> 3 stalls
    drive(1, 0, 0, 0, 0, 3, 1, 0, 0);
    repeat (4) drive(1, 3, 0, 1, 0, 0, 0, 0, 0);
    nop();
    chk("t2_stallCnt", stallCnt, 3);

    // 3: writer two ahead -> 2 stalls; same with useRt=0 -> none
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0);
    nop();
    repeat (3) drive(1, 0, 5, 0, 1, 0, 0, 0, 0);
    nop();
    chk("t3_stallCnt", stallCnt, 5);
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0);
    nop();
    repeat (3) drive(1, 0, 5, 0, 0, 0, 0, 0, 0);
    nop();
    chk("t3_nohaz_stallCnt", stallCnt, 5);

    // 4: branch in second stall cycle kills the decode writer of R6
    drive(1, 0, 0, 0, 0, 2, 1, 0, 0);
    drive(1, 2, 0, 1, 0, 6, 1, 0, 0);
    drive(1, 2, 0, 1, 0, 6, 1, 0, 1);
    drive(1, 6, 0, 1, 0, 0, 0, 0, 0);
    chk("t4_stallCnt", stallCnt, 6);

    // 5: halt drain to HALTED, then a halt cancelled by a branch
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0);
    repeat (5) nop();
    chk("t5_halted", halted, 1);
    do_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0);
    nop();
    nop(1);
    nop();
    nop();
    chk("t5b_halted", halted, 0);
    chk("t5b_pcWrEn", pcWrEn, 1);

    // 6: counter saturation, then watchdog via forced hazard
    force dut.stallCnt = 16'hFFFE;
    #1 release dut.stallCnt;
    m_cnt = 16'hFFFE;
    drive(1, 0, 0, 0, 0, 1, 1, 0, 0);
    repeat (4) drive(1, 1, 0, 1, 0, 0, 0, 0, 0);
    nop();
    chk("t6_sat", stallCnt, 16'hFFFF);
    force dut.hz = 1'b1;
    f_hz = 1;
    repeat (5) nop();
    release dut.hz;
    f_hz = 0;
    nop();
    chk("t6_err", err, 1);
    repeat (3) nop();
    chk("t6_err_sticky", err, 1);
    do_reset();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      if (m_mode == 2 && $urandom_range(0, 3) == 0) do_reset();
      else drive($urandom_range(0, 7) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7),
                 $urandom_range(0, 1), $urandom_range(0, 31) == 0, $urandom_range(0, 7) == 0);
    end
    nop();
    @(posedge clk); #1;
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
